// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 peripheral that issues register read/write strobes.
// SPI pins are oversampled in the clk domain; one command byte plus one data byte per frame.
module spi_reg_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       read,
    output logic       write,
    output logic [5:0] addr,
    output logic [7:0] data_write,
    input  logic [7:0] data_read,
    output logic       frame_err
);
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, vld;
    logic sclk_d, armed, rw;
    logic [2:0] bitcnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic sclk_s, cs_s, mosi_s, rise, fall;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;
    assign fall   = ~sclk_s & sclk_d;
    assign miso   = tx_sr[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync  <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            vld        <= '0;
            sclk_d     <= 1'b0;
            armed      <= 1'b0;
            rw         <= 1'b0;
            state      <= IDLE;
            bitcnt     <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            data_write <= '0;
            frame_err  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            vld       <= {vld[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            read      <= 1'b0;
            write     <= 1'b0;
            frame_err <= 1'b0;
            if (read)
                tx_sr <= data_read;
            if (state != IDLE && cs_s) begin
                state     <= IDLE;
                bitcnt    <= '0;
                tx_sr     <= '0;
                frame_err <= state == DATA || (state == CMD && bitcnt != 3'd0);
            end else if (state == IDLE) begin
                // only a genuinely observed high cs_n (not the reset fill) arms the next frame
                armed <= armed | (cs_s & vld[SYNC_STAGES-1]);
                if (armed && !cs_s) begin
                    state  <= CMD;
                    armed  <= 1'b0;
                    bitcnt <= '0;
                    rx_sr  <= '0;
                end
            end else if (state != DONE && rise) begin
                rx_sr  <= {rx_sr[5:0], mosi_s};
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7 && state == CMD) begin
                    addr  <= {rx_sr[4:0], mosi_s};
                    rw    <= rx_sr[6];
                    read  <= ~rx_sr[6];
                    state <= DATA;
                end else if (bitcnt == 3'd7) begin
                    if (rw)
                        data_write <= {rx_sr, mosi_s};
                    write <= rw;
                    tx_sr <= '0;
                    state <= DONE;
                end
            end else if (state == DATA && fall && bitcnt != 3'd0) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: host-level SPI frames against a transaction/register model of the bridge.
module tb_spi_reg_bridge;
    logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic miso, read, write, frame_err;
    logic [5:0] addr;
    logic [7:0] data_write, data_read;
    int vectors = 0, miscompares = 0;
    typedef struct packed {logic wr; logic [5:0] a; logic [7:0] d;} ev_t;
    ev_t exp_q[$];
    ev_t ev;
    int exp_err = 0, err_seen = 0;
    bit [7:0] mregs [64];
    bit [7:0] wval [64];
    bit written [64];

    spi_reg_bridge #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .read(read), .write(write), .addr(addr), .data_write(data_write),
        .data_read(data_read), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [5:0] a);
        return (a == 6'd13) ? 8'hA5 : 8'(a * 29 + 7);
    endfunction

    // register block seen by the bridge: power-up pattern overlaid by received writes
    assign data_read = written[addr] ? wval[addr] : init_val(addr);
    always @(posedge clk)
        if (write) begin
            written[addr] <= 1'b1;
            wval[addr]    <= data_write;
        end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (read || write) begin
            if (exp_q.size() == 0)
                check("unexpected strobe {read,write}", {30'd0, read, write}, 32'd0);
            else begin
                ev = exp_q.pop_front();
                check("strobe {read,write}", {30'd0, read, write}, ev.wr ? 32'd1 : 32'd2);
                check("strobe addr", {26'd0, addr}, {26'd0, ev.a});
                if (ev.wr)
                    check("write data", {24'd0, data_write}, {24'd0, ev.d});
            end
        end
        if (frame_err) begin
            err_seen++;
            check("frame_err expected", {31'd0, exp_err > 0}, 32'd1);
            if (exp_err > 0)
                exp_err--;
        end
    end

    task automatic send_frame(input logic [23:0] bytes, input int nbits, input int rst_bit,
                              input int gap, output logic [7:0] rx);
        logic [7:0] cmd, exp_rd;
        logic exp_bit;
        int done_bits;
        cmd = bytes[23:16];
        exp_rd = mregs[cmd[5:0]];
        done_bits = (rst_bit >= 0 && rst_bit < nbits) ? rst_bit : nbits;
        if (done_bits >= 8 && !cmd[7])
            exp_q.push_back('{1'b0, cmd[5:0], 8'h00});
        if (done_bits >= 16 && cmd[7]) begin
            exp_q.push_back('{1'b1, cmd[5:0], bytes[15:8]});
            mregs[cmd[5:0]] = bytes[15:8];
        end
        if (done_bits == nbits && nbits > 0 && nbits < 16)
            exp_err++;
        rx = 8'h00;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst read", {31'd0, read}, 32'd0);
                check("rst write", {31'd0, write}, 32'd0);
                check("rst addr", {26'd0, addr}, 32'd0);
                check("rst data_write", {24'd0, data_write}, 32'd0);
                check("rst miso", {31'd0, miso}, 32'd0);
                check("rst frame_err", {31'd0, frame_err}, 32'd0);
                rst = 1'b0;
                break;
            end
            mosi = bytes[23 - i];
            repeat (4) @(negedge clk);
            exp_bit = (i >= 8 && i < 16 && !cmd[7]) ? exp_rd[15 - i] : 1'b0;
            check("miso bit", {31'd0, miso}, {31'd0, exp_bit});
            if (i >= 8 && i < 16)
                rx[15 - i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drained(input string name);
        check({name, " strobes pending"}, exp_q.size(), 32'd0);
        check({name, " frame_err pending"}, exp_err, 32'd0);
        check({name, " idle miso"}, {31'd0, miso}, 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        logic [23:0] b;
        int e0, k, nb;
        for (int i = 0; i < 64; i++)
            mregs[i] = init_val(6'(i));
        repeat (3) @(negedge clk);
        check("reset read", {31'd0, read}, 32'd0);
        check("reset write", {31'd0, write}, 32'd0);
        check("reset addr", {26'd0, addr}, 32'd0);
        check("reset data_write", {24'd0, data_write}, 32'd0);
        check("reset miso", {31'd0, miso}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        send_frame(24'h823400, 16, -1, 6, rx);
        drained("write 82 34");
        check("write addr", {26'd0, addr}, 32'h02);
        check("write data_write", {24'd0, data_write}, 32'h34);

        send_frame(24'h0D0000, 16, -1, 6, rx);
        drained("read 0D");
        check("read 0D byte", {24'd0, rx}, 32'hA5);

        send_frame(24'h80FF00, 16, -1, 4, rx);
        send_frame(24'h000000, 16, -1, 6, rx);
        drained("back-to-back");
        check("b2b readback", {24'd0, rx}, 32'hFF);
        check("b2b data_write", {24'd0, data_write}, 32'hFF);

        e0 = err_seen;
        send_frame(24'h83AB00, 13, -1, 6, rx);
        drained("abort");
        check("abort frame_err pulses", err_seen - e0, 32'd1);
        check("abort data_write held", {24'd0, data_write}, 32'hFF);
        send_frame(24'h83C300, 16, -1, 6, rx);
        drained("after abort");
        check("after abort addr", {26'd0, addr}, 32'h03);
        check("after abort data_write", {24'd0, data_write}, 32'hC3);

        send_frame(24'h811122, 24, -1, 6, rx);
        drained("three-byte");
        check("three-byte addr", {26'd0, addr}, 32'h01);
        check("three-byte data_write", {24'd0, data_write}, 32'h11);

        send_frame(24'h030000, 16, 11, 6, rx);
        drained("reset mid-read");
        send_frame(24'h030000, 16, -1, 6, rx);
        drained("after reset");
        check("after reset readback", {24'd0, rx}, 32'hC3);

        for (int n = 0; n < 40; n++) begin
            b = 24'($urandom);
            k = $urandom_range(0, 9);
            nb = (k < 6) ? 16 : (k < 7) ? 24 : $urandom_range(0, 15);
            send_frame(b, nb, -1, $urandom_range(4, 8), rx);
            drained("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
